multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 63 ++++++
 rtl/alu_decoder.sv | 26 ++
 rtl/multicycle_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared encodings for the multicycle RISC-V control unit
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR1    = 4'd11,
        S_JALR2    = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Immediate format is a pure function of the opcode, independent of state.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - funct3/funct7 to ALU operation decode with unsupported-funct flag
module alu_decoder
    import multicycle_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    output logic [2:0] alu_control,
    output logic       bad_funct
);

    // funct3 codes outside the decoded set raise bad_funct so the FSM traps.
    always_comb begin
        alu_control = ALU_ADD;
        bad_funct   = 1'b0;
        case (funct3)
            3'b000:  alu_control = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_control = ALU_SLT;
            3'b100:  alu_control = ALU_XOR;
            3'b110:  alu_control = ALU_OR;
            3'b111:  alu_control = ALU_AND;
            default: bad_funct   = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore FSM controller for a multicycle RV32I subset datapath
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       ALUR31,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       jalr,
    output logic       illegal,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl
);

    state_t     r_state;
    state_t     w_next_state;

    logic       w_is_rtype;
    logic [2:0] w_dec_alu;
    logic       w_bad_funct;
    logic       w_take;
    logic       w_bad_branch;

    logic       w_pcwrite;
    logic       w_irwrite;
    logic       w_regwrite;
    logic       w_memwrite;
    logic       w_adrsrc;
    logic       w_jalr;
    logic       w_illegal;
    logic [1:0] w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_resultsrc;
    logic [2:0] w_alucontrol;

    // funct7b5 only selects subtract for register-register ops; immediates ignore it.
    assign w_is_rtype = (r_state == S_EXECR);

    alu_decoder u_alu_decoder (
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .is_rtype    (w_is_rtype),
        .alu_control (w_dec_alu),
        .bad_funct   (w_bad_funct)
    );

    // Branch condition from the subtract result flags; unsupported conditions trap.
    always_comb begin
        w_take       = 1'b0;
        w_bad_branch = 1'b0;
        case (funct3)
            3'b000:  w_take = Zero;
            3'b001:  w_take = ~Zero;
            3'b100:  w_take = ALUR31;
            3'b101:  w_take = ~ALUR31;
            default: w_bad_branch = 1'b1;
        endcase
    end

    // State register; reset returns to FETCH without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and Moore outputs; anything a state does not mention stays at zero.
    always_comb begin
        w_next_state = r_state;
        w_pcwrite    = 1'b0;
        w_irwrite    = 1'b0;
        w_regwrite   = 1'b0;
        w_memwrite   = 1'b0;
        w_adrsrc     = 1'b0;
        w_jalr       = 1'b0;
        w_illegal    = 1'b0;
        w_alusrca    = SRCA_PC;
        w_alusrcb    = SRCB_RS2;
        w_resultsrc  = RES_ALUOUT;
        w_alucontrol = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_alusrca   = SRCA_PC;
                w_alusrcb   = SRCB_FOUR;
                w_resultsrc = RES_ALURESULT;
                w_irwrite   = mem_ready;
                w_pcwrite   = mem_ready;
                if (mem_ready) begin
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                w_alusrca = SRCA_OLDPC;
                w_alusrcb = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
                    OP_RTYPE:          w_next_state = S_EXECR;
                    OP_ITYPE:          w_next_state = S_EXECI;
                    OP_BRANCH:         w_next_state = S_BRANCH;
                    OP_JAL:            w_next_state = S_JAL;
                    OP_JALR:           w_next_state = S_JALR1;
                    default:           w_next_state = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                w_alusrca    = SRCA_RS1;
                w_alusrcb    = SRCB_IMM;
                w_next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_adrsrc    = 1'b1;
                w_resultsrc = RES_ALUOUT;
                if (mem_ready) begin
                    w_next_state = S_MEMWB;
                end
            end
            S_MEMWB: begin
                w_resultsrc  = RES_MEMDATA;
                w_regwrite   = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adrsrc    = 1'b1;
                w_resultsrc = RES_ALUOUT;
                w_memwrite  = 1'b1;
                if (mem_ready) begin
                    w_next_state = S_FETCH;
                end
            end
            S_EXECR: begin
                w_alusrca    = SRCA_RS1;
                w_alusrcb    = SRCB_RS2;
                w_alucontrol = w_dec_alu;
                w_next_state = w_bad_funct ? S_TRAP : S_ALUWB;
            end
            S_EXECI: begin
                w_alusrca    = SRCA_RS1;
                w_alusrcb    = SRCB_IMM;
                w_alucontrol = w_dec_alu;
                w_next_state = w_bad_funct ? S_TRAP : S_ALUWB;
            end
            S_ALUWB: begin
                w_resultsrc  = RES_ALUOUT;
                w_regwrite   = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                w_alusrca    = SRCA_RS1;
                w_alusrcb    = SRCB_RS2;
                w_alucontrol = ALU_SUB;
                w_resultsrc  = RES_ALUOUT;
                w_pcwrite    = w_take & ~w_bad_branch;
                w_next_state = w_bad_branch ? S_TRAP : S_FETCH;
            end
            S_JAL: begin
                w_alusrca    = SRCA_OLDPC;
                w_alusrcb    = SRCB_FOUR;
                w_resultsrc  = RES_ALUOUT;
                w_pcwrite    = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_JALR1: begin
                w_alusrca    = SRCA_RS1;
                w_alusrcb    = SRCB_IMM;
                w_next_state = S_JALR2;
            end
            S_JALR2: begin
                w_alusrca    = SRCA_OLDPC;
                w_alusrcb    = SRCB_FOUR;
                w_resultsrc  = RES_ALUOUT;
                w_pcwrite    = 1'b1;
                w_jalr       = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_TRAP: begin
                w_illegal    = 1'b1;
                w_next_state = S_TRAP;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // Write enables are masked by reset so an interrupted access never commits.
    assign PCWrite    = w_pcwrite  & ~reset;
    assign IRWrite    = w_irwrite  & ~reset;
    assign RegWrite   = w_regwrite & ~reset;
    assign MemWrite   = w_memwrite & ~reset;
    assign AdrSrc     = w_adrsrc;
    assign jalr       = w_jalr;
    assign illegal    = w_illegal;
    assign ALUSrcA    = w_alusrca;
    assign ALUSrcB    = w_alusrcb;
    assign ResultSrc  = w_resultsrc;
    assign ALUControl = w_alucontrol;
    assign ImmSrc     = imm_src_of(op);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table and scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       ALUR31 = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, jalr, illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0] ALUControl;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .ALUR31     (ALUR31),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .AdrSrc     (AdrSrc),
        .jalr       (jalr),
        .illegal    (illegal),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] EN_PC   = 7'b1000000;
    localparam logic [6:0] EN_IR   = 7'b0100000;
    localparam logic [6:0] EN_RW   = 7'b0010000;
    localparam logic [6:0] EN_MW   = 7'b0001000;
    localparam logic [6:0] EN_ADR  = 7'b0000100;
    localparam logic [6:0] EN_JALR = 7'b0000010;
    localparam logic [6:0] EN_ILL  = 7'b0000001;
    localparam logic [17:0] M_ALL  = 18'h3ffff;
    localparam logic [17:0] M_NOALU = 18'h3fff8;

    localparam int K_LOAD = 0, K_STORE = 1, K_R = 2, K_I = 3, K_BR = 4, K_JAL = 5,
                   K_JALR = 6, K_BAD_R = 7, K_BAD_I = 8, K_BAD_BR = 9;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
        logic       r31;
        int         kind;
        logic [2:0] exp_alu;
        logic       exp_take;
        logic [1:0] exp_imm;
        string      name;
    } vec_t;

    typedef struct {
        logic        rst;
        logic        mr;
        logic        nowait;
        logic [17:0] word;
        logic [17:0] mask;
        string       tag;
    } ent_t;

    vec_t tbl[$];
    ent_t q[$];
    int   n_checks = 0;
    int   n_fails = 0;

    function automatic logic [17:0] mk(input logic [6:0] en, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] res,
                                       input logic [1:0] imm, input logic [2:0] alu);
        return {en, a, b, res, imm, alu};
    endfunction

    function automatic vec_t mkv(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                 input logic z, input logic r, input int k, input logic [2:0] alu,
                                 input logic take, input logic [1:0] imm, input string nm);
        vec_t v;
        v.op = o; v.f3 = f3; v.f7 = f7; v.zero = z; v.r31 = r; v.kind = k;
        v.exp_alu = alu; v.exp_take = take; v.exp_imm = imm; v.name = nm;
        return v;
    endfunction

    task automatic push(input logic rst, input logic mr, input logic nw,
                        input logic [17:0] word, input logic [17:0] mask, input string tag);
        ent_t e;
        e.rst = rst; e.mr = mr; e.nowait = nw; e.word = word; e.mask = mask; e.tag = tag;
        q.push_back(e);
    endtask

    // Each scoreboard entry is one cycle: drive its stimulus mid-cycle, then compare.
    task automatic run_queue();
        ent_t        e;
        logic [17:0] act;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (!e.nowait) @(negedge clk);
            reset     = e.rst;
            mem_ready = e.mr;
            #1;
            act = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, jalr, illegal,
                   ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};
            n_checks++;
            if ((act & e.mask) !== (e.word & e.mask)) begin
                n_fails++;
                $display("FAIL %s: got %05h want %05h (mask %05h)", e.tag, act, e.word, e.mask);
            end
        end
    endtask

    // Instruction fields change just after a rising edge, when the DUT sits in FETCH.
    task automatic start_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                               input logic z, input logic r);
        @(posedge clk);
        #1;
        op = o; funct3 = f3; funct7b5 = f7; Zero = z; ALUR31 = r;
    endtask

    task automatic push_traps(input logic [1:0] imm, input int n, input string nm);
        for (int i = 0; i < n; i++)
            push(1'b0, i[0], 1'b0, mk(EN_ILL, 2'b00, 2'b00, 2'b00, imm, 3'b000), M_ALL,
                 $sformatf("%s/trap%0d", nm, i));
        push(1'b1, 1'b1, 1'b0, mk(7'd0, 2'b00, 2'b10, 2'b10, imm, 3'b000), M_ALL,
             {nm, "/reset_fetch"});
    endtask

    task automatic push_vec(input vec_t v);
        logic [1:0] imm;
        imm = v.exp_imm;
        push(1'b0, 1'b1, 1'b0, mk(EN_PC | EN_IR, 2'b00, 2'b10, 2'b10, imm, 3'b000), M_ALL, {v.name, "/fetch"});
        push(1'b0, 1'b1, 1'b0, mk(7'd0, 2'b01, 2'b01, 2'b00, imm, 3'b000), M_ALL, {v.name, "/decode"});
        case (v.kind)
            K_LOAD: begin
                push(1'b0, 1'b1, 1'b0, mk(7'd0, 2'b10, 2'b01, 2'b00, imm, 3'b000), M_ALL, {v.name, "/memadr"});
                push(1'b0, 1'b1, 1'b0, mk(EN_ADR, 2'b00, 2'b00, 2'b00, imm, 3'b000), M_ALL, {v.name, "/memread"});
                push(1'b0, 1'b1, 1'b0, mk(EN_RW, 2'b00, 2'b00, 2'b01, imm, 3'b000), M_ALL, {v.name, "/memwb"});
            end
            K_STORE: begin
                push(1'b0, 1'b1, 1'b0, mk(7'd0, 2'b10, 2'b01, 2'b00, imm, 3'b000), M_ALL, {v.name, "/memadr"});
                push(1'b0, 1'b1, 1'b0, mk(EN_ADR | EN_MW, 2'b00, 2'b00, 2'b00, imm, 3'b000), M_ALL, {v.name, "/memwrite"});
            end
            K_R, K_I: begin
                push(1'b0, 1'b1, 1'b0, mk(7'd0, 2'b10, (v.kind == K_R) ? 2'b00 : 2'b01, 2'b00, imm, v.exp_alu),
                     M_ALL, {v.name, "/exec"});
                push(1'b0, 1'b1, 1'b0, mk(EN_RW, 2'b00, 2'b00, 2'b00, imm, 3'b000), M_ALL, {v.name, "/aluwb"});
            end
            K_BR: begin
                push(1'b0, 1'b1, 1'b0, mk(v.exp_take ? EN_PC : 7'd0, 2'b10, 2'b00, 2'b00, imm, 3'b001),
                     M_ALL, {v.name, "/branch"});
            end
            K_JAL: begin
                push(1'b0, 1'b1, 1'b0, mk(EN_PC, 2'b01, 2'b10, 2'b00, imm, 3'b000), M_ALL, {v.name, "/jal"});
                push(1'b0, 1'b1, 1'b0, mk(EN_RW, 2'b00, 2'b00, 2'b00, imm, 3'b000), M_ALL, {v.name, "/aluwb"});
            end
            K_JALR: begin
                push(1'b0, 1'b1, 1'b0, mk(7'd0, 2'b10, 2'b01, 2'b00, imm, 3'b000), M_ALL, {v.name, "/jalr1"});
                push(1'b0, 1'b1, 1'b0, mk(EN_PC | EN_JALR, 2'b01, 2'b10, 2'b00, imm, 3'b000), M_ALL, {v.name, "/jalr2"});
                push(1'b0, 1'b1, 1'b0, mk(EN_RW, 2'b00, 2'b00, 2'b00, imm, 3'b000), M_ALL, {v.name, "/aluwb"});
            end
            K_BAD_R, K_BAD_I: begin
                push(1'b0, 1'b1, 1'b0, mk(7'd0, 2'b10, (v.kind == K_BAD_R) ? 2'b00 : 2'b01, 2'b00, imm, 3'b000),
                     M_NOALU, {v.name, "/exec"});
                push_traps(imm, 3, v.name);
            end
            default: begin
                push(1'b0, 1'b1, 1'b0, mk(7'd0, 2'b10, 2'b00, 2'b00, imm, 3'b001), M_ALL, {v.name, "/branch"});
                push_traps(imm, 3, v.name);
            end
        endcase
    endtask

    initial begin
        tbl.push_back(mkv(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, K_R,  3'b000, 1'b0, 2'b00, "add"));
        tbl.push_back(mkv(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, K_R,  3'b001, 1'b0, 2'b00, "sub"));
        tbl.push_back(mkv(7'b0110011, 3'b010, 1'b0, 1'b0, 1'b0, K_R,  3'b101, 1'b0, 2'b00, "slt"));
        tbl.push_back(mkv(7'b0110011, 3'b100, 1'b0, 1'b0, 1'b0, K_R,  3'b100, 1'b0, 2'b00, "xor"));
        tbl.push_back(mkv(7'b0110011, 3'b110, 1'b0, 1'b0, 1'b0, K_R,  3'b011, 1'b0, 2'b00, "or"));
        tbl.push_back(mkv(7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0, K_R,  3'b010, 1'b0, 2'b00, "and"));
        tbl.push_back(mkv(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, K_I,  3'b000, 1'b0, 2'b00, "addi_f7"));
        tbl.push_back(mkv(7'b0010011, 3'b100, 1'b0, 1'b0, 1'b0, K_I,  3'b100, 1'b0, 2'b00, "xori"));
        tbl.push_back(mkv(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, K_LOAD, 3'b000, 1'b0, 2'b00, "lw"));
        tbl.push_back(mkv(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, K_STORE, 3'b000, 1'b0, 2'b01, "sw"));
        tbl.push_back(mkv(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, K_BR, 3'b001, 1'b1, 2'b10, "beq_z1"));
        tbl.push_back(mkv(7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0, K_BR, 3'b001, 1'b0, 2'b10, "beq_z0"));
        tbl.push_back(mkv(7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, K_BR, 3'b001, 1'b1, 2'b10, "bne_z0"));
        tbl.push_back(mkv(7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1, K_BR, 3'b001, 1'b1, 2'b10, "blt_n1"));
        tbl.push_back(mkv(7'b1100011, 3'b101, 1'b0, 1'b0, 1'b1, K_BR, 3'b001, 1'b0, 2'b10, "bge_n1"));
        tbl.push_back(mkv(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, K_JAL, 3'b000, 1'b0, 2'b11, "jal"));
        tbl.push_back(mkv(7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, K_JALR, 3'b000, 1'b0, 2'b00, "jalr"));
        tbl.push_back(mkv(7'b0110011, 3'b001, 1'b0, 1'b0, 1'b0, K_BAD_R, 3'b000, 1'b0, 2'b00, "sll_trap"));
        tbl.push_back(mkv(7'b0010011, 3'b101, 1'b0, 1'b0, 1'b0, K_BAD_I, 3'b000, 1'b0, 2'b00, "srli_trap"));
        tbl.push_back(mkv(7'b1100011, 3'b010, 1'b0, 1'b1, 1'b1, K_BAD_BR, 3'b001, 1'b0, 2'b10, "br010_trap"));

        // Reset state: FETCH selects with write enables forced low, then FETCH waiting on memory.
        push(1'b1, 1'b1, 1'b0, mk(7'd0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000), M_ALL, "reset_fetch");
        push(1'b0, 1'b0, 1'b0, mk(7'd0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000), M_ALL, "fetch_wait");
        run_queue();

        foreach (tbl[i]) begin
            start_instr(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].zero, tbl[i].r31);
            push_vec(tbl[i]);
            run_queue();
        end

        // lw with three memory wait cycles; mem_ready low in DECODE/MEMADR must not stall.
        start_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b1, 1'b0, mk(EN_PC | EN_IR, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000), M_ALL, "lwwait/fetch");
        push(1'b0, 1'b0, 1'b0, mk(7'd0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000), M_ALL, "lwwait/decode");
        push(1'b0, 1'b0, 1'b0, mk(7'd0, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000), M_ALL, "lwwait/memadr");
        for (int i = 0; i < 4; i++)
            push(1'b0, (i == 3), 1'b0, mk(EN_ADR, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), M_ALL,
                 $sformatf("lwwait/memread%0d", i));
        push(1'b0, 1'b0, 1'b0, mk(EN_RW, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000), M_ALL, "lwwait/memwb");
        push(1'b0, 1'b0, 1'b0, mk(7'd0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000), M_ALL, "lwwait/next_fetch");
        run_queue();

        // sw interrupted by reset while MemWrite is held waiting for memory.
        start_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b1, 1'b0, mk(EN_PC | EN_IR, 2'b00, 2'b10, 2'b10, 2'b01, 3'b000), M_ALL, "swrst/fetch");
        push(1'b0, 1'b0, 1'b0, mk(7'd0, 2'b01, 2'b01, 2'b00, 2'b01, 3'b000), M_ALL, "swrst/decode");
        push(1'b0, 1'b0, 1'b0, mk(7'd0, 2'b10, 2'b01, 2'b00, 2'b01, 3'b000), M_ALL, "swrst/memadr");
        push(1'b0, 1'b0, 1'b0, mk(EN_ADR | EN_MW, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000), M_ALL, "swrst/memwrite0");
        push(1'b0, 1'b0, 1'b0, mk(EN_ADR | EN_MW, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000), M_ALL, "swrst/memwrite1");
        push(1'b1, 1'b1, 1'b1, mk(7'd0, 2'b00, 2'b10, 2'b10, 2'b01, 3'b000), M_ALL, "swrst/same_cycle");
        push(1'b1, 1'b1, 1'b0, mk(7'd0, 2'b00, 2'b10, 2'b10, 2'b01, 3'b000), M_ALL, "swrst/held");
        run_queue();
        start_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0);
        push_vec(tbl[0]);
        run_queue();

        // Unknown opcode parks in TRAP for ten cycles until reset.
        start_instr(7'b0001111, 3'b000, 1'b0, 1'b1, 1'b1);
        push(1'b0, 1'b1, 1'b0, mk(EN_PC | EN_IR, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000), M_ALL, "fence/fetch");
        push(1'b0, 1'b1, 1'b0, mk(7'd0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000), M_ALL, "fence/decode");
        push_traps(2'b00, 10, "fence");
        run_queue();
        start_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0);
        push_vec(tbl[15]);
        run_queue();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
